// File: rtl/exec_ctrl.sv
// Execute-stage sequencer for multi-cycle FPU ops: holds the stage busy for the
// per-operation latency, raises fin on completion and keeps FPU perf counters.
module exec_ctrl #(
   parameter int unsigned LAT_FADD    = 2,
   parameter int unsigned LAT_FMUL    = 2,
   parameter int unsigned LAT_FDIV    = 10,
   parameter int unsigned LAT_FSQRT   = 8,
   parameter int unsigned LAT_FCVT    = 1,
   parameter int unsigned LAT_DEFAULT = 0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        enable,
   input  logic        flush,
   input  logic        aluorfpu,
   input  logic [3:0]  fpuop,
   output logic        fin,
   output logic        busy,
   output logic        stall,
   output logic [31:0] fpu_cycles,
   output logic [31:0] fpu_ops
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [3:0]  lat;
   logic        ops_inc;
   logic [31:0] cycles_nxt, ops_nxt;

   always_comb begin
      lat = '0;
      if (aluorfpu) begin
         case (fpuop)
            4'd0, 4'd1: lat = 4'(LAT_FADD);
            4'd2:       lat = 4'(LAT_FMUL);
            4'd3:       lat = 4'(LAT_FDIV);
            4'd4:       lat = 4'(LAT_FSQRT);
            4'd5:       lat = 4'(LAT_FCVT);
            default:    lat = 4'(LAT_DEFAULT);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (!flush && enable && lat != 4'd0) begin
               state_nxt = RUN;
               cnt_nxt   = lat - 4'd1;
            end
         end
         RUN: begin
            if (flush || cnt == 4'd0) state_nxt = IDLE;
            else                      cnt_nxt   = cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      fin     = 1'b0;
      busy    = 1'b0;
      ops_inc = 1'b0;
      case (state)
         IDLE: begin
            if (enable && !flush && lat == 4'd0) begin
               fin     = 1'b1;
               ops_inc = aluorfpu;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (!flush && cnt == 4'd0) begin
               fin     = enable;
               ops_inc = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign stall = enable & ~fin;

   // Counters are rewritten every edge so a held value simply recirculates.
   always_comb begin
      cycles_nxt = fpu_cycles;
      ops_nxt    = fpu_ops;
      if (state == RUN && fpu_cycles != '1) cycles_nxt = fpu_cycles + 32'd1;
      if (ops_inc && fpu_ops != '1)         ops_nxt    = fpu_ops + 32'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fpu_cycles <= '0;
         fpu_ops    <= '0;
      end else begin
         fpu_cycles <= cycles_nxt;
         fpu_ops    <= ops_nxt;
      end
   end

endmodule
